// File: rtl/adc_sample_packer_if.sv
// ADC sample strobe in, framed byte stream out. The master side drives samples and tx_ready.
interface adc_sample_packer_if;
   logic        drdy;
   logic [15:0] dataout;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output drdy,
      output dataout,
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

   modport slave (
      input  drdy,
      input  dataout,
      output tx_data,
      output tx_valid,
      input  tx_ready
   );
endinterface

// File: rtl/adc_sample_packer.sv
// Buffers {seq, sample} words and emits 5-byte packets (sync, seq, msb, lsb, csum); first byte 2 cycles after drdy.
// Registered outputs; tx_valid holds until tx_ready, samples arriving while the FIFO is full are dropped.

module adc_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Caller only writes when not full and only reads when not empty.
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module adc_sample_packer #(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                          clk,
   input  logic                          reset,
   adc_sample_packer_if.slave            stream,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          busy
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SYNC, SEQ, MSB, LSB, CSUM} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  seq;
   logic [7:0]  pkt_seq;
   logic [15:0] pkt_sample;
   logic [23:0] head;
   logic [7:0]  csum;
   logic [7:0]  byte_nxt;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic        wr_en;
   logic        pop;

   // Full check uses the count before this cycle's pop, so write+pop at full drops.
   assign wr_en = stream.drdy && (fifo_count < FULL_COUNT);
   assign csum  = pkt_seq + pkt_sample[15:8] + pkt_sample[7:0];

   adc_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (24)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en),
      .wr_dat ({seq, stream.dataout}),
      .rd_en  (pop),
      .rd_dat (head),
      .count  (fifo_count)
   );

   // tx_valid is high in every non-IDLE state, so tx_ready alone qualifies acceptance.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      byte_nxt  = 8'h00;
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop       = 1'b1;
               state_nxt = SYNC;
            end
         end
         SYNC:    if (stream.tx_ready) state_nxt = SEQ;
         SEQ:     if (stream.tx_ready) state_nxt = MSB;
         MSB:     if (stream.tx_ready) state_nxt = LSB;
         LSB:     if (stream.tx_ready) state_nxt = CSUM;
         CSUM:    if (stream.tx_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      case (state_nxt)
         SYNC:    byte_nxt = SYNC_BYTE;
         SEQ:     byte_nxt = pkt_seq;
         MSB:     byte_nxt = pkt_sample[15:8];
         LSB:     byte_nxt = pkt_sample[7:0];
         CSUM:    byte_nxt = csum;
         default: byte_nxt = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         seq        <= 8'h00;
         overflow   <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         pkt_seq    <= 8'h00;
         pkt_sample <= 16'h0000;
      end else begin
         state      <= state_nxt;
         tx_valid_q <= (state_nxt != IDLE);
         tx_data_q  <= byte_nxt;
         if (stream.drdy) begin
            seq <= seq + 8'h01;
         end
         if (stream.drdy && !wr_en) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            pkt_seq    <= head[23:16];
            pkt_sample <= head[15:0];
         end
      end
   end

   assign stream.tx_data  = tx_data_q;
   assign stream.tx_valid = tx_valid_q;
   assign busy            = tx_valid_q;
endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer: reset, single packet, backpressure, overflow, seq wrap, reset mid-packet.
module tb_adc_sample_packer;
   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       busy;
   logic [7:0] rxq [$];
   logic [7:0] cs;
   int         n_tests = 0;
   int         n_fail  = 0;

   adc_sample_packer_if stream ();

   adc_sample_packer #(
      .FIFO_DEPTH (16),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stream     (stream),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Bytes handed over at the coming rising edge.
   always @(negedge clk) begin
      if (reset === 1'b0 && stream.tx_valid === 1'b1 && stream.tx_ready === 1'b1) begin
         rxq.push_back(stream.tx_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      stream.drdy = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      rxq.delete();
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int cyc = 0;
      while (rxq.size() < n && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic expect_pkt(input string tag, input logic [7:0] s, input logic [15:0] d,
                             output logic [7:0] cs_seen);
      logic [7:0] b [5];
      logic [7:0] exp_cs;
      wait_bytes(5, 200);
      check({tag, "_nbytes"}, 32'(rxq.size() >= 5), 32'd1);
      for (int k = 0; k < 5; k++) begin
         b[k] = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      end
      exp_cs = s + d[15:8] + d[7:0];
      check({tag, "_sync"}, b[0], 8'hA5);
      check({tag, "_seq"},  b[1], s);
      check({tag, "_msb"},  b[2], d[15:8]);
      check({tag, "_lsb"},  b[3], d[7:0]);
      check({tag, "_csum"}, b[4], exp_cs);
      cs_seen = b[4];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int valid_seen;
      reset           = 1'b1;
      stream.drdy     = 1'b0;
      stream.dataout  = 16'h0000;
      stream.tx_ready = 1'b0;

      // Reset held with drdy toggling
      for (int i = 0; i < 3; i++) begin
         stream.drdy = ~stream.drdy;
         tick();
      end
      check("t1_tx_data",  stream.tx_data, 8'h00);
      check("t1_tx_valid", stream.tx_valid, 1'b0);
      check("t1_count",    fifo_count, 5'd0);
      check("t1_overflow", overflow, 1'b0);
      check("t1_busy",     busy, 1'b0);
      reset           = 1'b0;
      stream.drdy     = 1'b0;
      stream.tx_ready = 1'b1;
      valid_seen      = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (stream.tx_valid !== 1'b0) valid_seen++;
      end
      check("t1_no_valid", valid_seen, 0);

      // Single sample, unthrottled
      rxq.delete();
      stream.dataout = 16'h1234;
      stream.drdy    = 1'b1;
      tick();
      stream.drdy = 1'b0;
      @(negedge clk);
      check("t2_count_after_strobe", fifo_count, 5'd1);
      check("t2_valid_after_strobe", stream.tx_valid, 1'b0);
      tick();
      @(negedge clk);
      check("t2_first_valid", stream.tx_valid, 1'b1);
      check("t2_first_byte",  stream.tx_data, 8'hA5);
      expect_pkt("t2", 8'h00, 16'h1234, cs);
      check("t2_csum_46", cs, 8'h46);
      repeat (3) tick();
      check("t2_count_empty", fifo_count, 5'd0);
      check("t2_busy_idle",   busy, 1'b0);

      // Same packet, stalled 7 cycles at the MSB byte
      do_reset();
      stream.tx_ready = 1'b1;
      stream.dataout  = 16'h1234;
      stream.drdy     = 1'b1;
      tick();
      stream.drdy = 1'b0;
      repeat (3) tick();
      check("t3_pre_stall_bytes", rxq.size(), 2);
      stream.tx_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check($sformatf("t3_hold_valid%0d", i), stream.tx_valid, 1'b1);
         check($sformatf("t3_hold_data%0d", i),  stream.tx_data, 8'h12);
         tick();
      end
      stream.tx_ready = 1'b1;
      expect_pkt("t3", 8'h00, 16'h1234, cs);
      check("t3_csum_46", cs, 8'h46);

      // Overflow: 18 back-to-back samples with the consumer stalled
      do_reset();
      stream.tx_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         stream.dataout = 16'(i);
         stream.drdy    = 1'b1;
         tick();
         if (i == 16) begin
            check("t4_count_at_full", fifo_count, 5'd16);
            check("t4_no_ovf_yet",    overflow, 1'b0);
         end
      end
      stream.drdy = 1'b0;
      check("t4_count_sat", fifo_count, 5'd16);
      check("t4_overflow",  overflow, 1'b1);
      check("t4_stall_valid", stream.tx_valid, 1'b1);
      stream.tx_ready = 1'b1;
      expect_pkt("t4_p00", 8'h00, 16'h0000, cs);
      for (int s = 1; s <= 16; s++) begin
         expect_pkt($sformatf("t4_p%02h", s), 8'(s), 16'(s), cs);
      end
      stream.dataout = 16'h00AB;
      stream.drdy    = 1'b1;
      tick();
      stream.drdy = 1'b0;
      expect_pkt("t4_gap", 8'h12, 16'h00AB, cs);
      check("t4_overflow_sticky", overflow, 1'b1);

      // Sequence wrap with all-ones samples
      do_reset();
      stream.tx_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         stream.dataout = 16'hFFFF;
         stream.drdy    = 1'b1;
         tick();
         stream.drdy = 1'b0;
         repeat (7) tick();
      end
      for (int i = 0; i < 257; i++) begin
         expect_pkt($sformatf("t5_%0d", i), 8'(i), 16'hFFFF, cs);
         if (i == 255) check("t5_csum_ff", cs, 8'hFD);
      end
      check("t5_overflow", overflow, 1'b0);

      // Reset while the LSB byte is on the bus, one more sample queued
      do_reset();
      stream.tx_ready = 1'b1;
      stream.dataout  = 16'h5678;
      stream.drdy     = 1'b1;
      tick();
      stream.dataout = 16'h1111;
      tick();
      stream.drdy = 1'b0;
      repeat (3) tick();
      check("t6_lsb_byte",  stream.tx_data, 8'h78);
      check("t6_lsb_valid", stream.tx_valid, 1'b1);
      check("t6_queued",    fifo_count, 5'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_valid_cleared", stream.tx_valid, 1'b0);
      check("t6_fifo_empty",    fifo_count, 5'd0);
      check("t6_busy_cleared",  busy, 1'b0);
      rxq.delete();
      repeat (3) tick();
      check("t6_no_resume", rxq.size(), 0);
      stream.dataout = 16'h9ABC;
      stream.drdy    = 1'b1;
      tick();
      stream.drdy = 1'b0;
      expect_pkt("t6_new", 8'h00, 16'h9ABC, cs);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
